// File: rtl/decoder_gate_arbiter.sv
// Four-requester arbiter feeding a decoder-based bitwise gate unit (XOR/XNOR/AND/OR).
// Round-robin by default; define DEC_ARB_FIXED_PRIO_EN for fixed priority (req[0] highest).
module decoder_gate_arbiter #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3:0]     req,
    input  logic [4*W-1:0] op_a,
    input  logic [4*W-1:0] op_b,
    input  logic [7:0]     op_sel,
    output logic [3:0]     gnt,
    output logic [W-1:0]   res,
    output logic [1:0]     res_id,
    output logic           res_valid,
    input  logic           res_ready,
    output logic           busy
);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        EXEC = 3'b010,
        RESP = 3'b100
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [1:0]     op_q, op_d;
    logic [1:0]     id_q, id_d;
    logic [3:0]     gnt_q, gnt_d;
    logic [W-1:0]   res_q, res_d;
    logic [1:0]     res_id_q, res_id_d;
    logic           res_valid_q, res_valid_d;

    logic           win_found;
    logic [1:0]     win_id;

    // Each result bit decodes {a,b} into one of four minterms and ORs the ones the op selects.
    function automatic logic [W-1:0] gate_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] op);
        logic [W-1:0] r;
        logic [3:0]   w;
        r = '0;
        for (int k = 0; k < W; k++) begin
            w = 4'b0001 << {a[k], b[k]};
            case (op)
                2'b00:   r[k] = w[1] | w[2];
                2'b01:   r[k] = w[0] | w[3];
                2'b10:   r[k] = w[3];
                default: r[k] = w[1] | w[2] | w[3];
            endcase
        end
        return r;
    endfunction

`ifdef DEC_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest-numbered active requester is the last one written.
    always_comb begin
        win_found = 1'b0;
        win_id    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) begin
                win_found = 1'b1;
                win_id    = 2'(i);
            end
        end
    end
`else
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] scan_idx;

    // Scan from the pointer outward; 2-bit addition provides the 3 -> 0 wrap.
    always_comb begin
        win_found = 1'b0;
        win_id    = 2'd0;
        scan_idx  = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            scan_idx = ptr_q + 2'(k);
            if (req[scan_idx]) begin
                win_found = 1'b1;
                win_id    = scan_idx;
            end
        end
    end
`endif

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        id_d        = id_q;
        gnt_d       = gnt_q;
        res_d       = res_q;
        res_id_d    = res_id_q;
        res_valid_d = res_valid_q;
`ifndef DEC_ARB_FIXED_PRIO_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    a_d     = op_a[win_id*W +: W];
                    b_d     = op_b[win_id*W +: W];
                    op_d    = op_sel[win_id*2 +: 2];
                    id_d    = win_id;
                    gnt_d   = 4'b0001 << win_id;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                gnt_d       = 4'b0000;
                res_d       = gate_f(a_q, b_q, op_q);
                res_id_d    = id_q;
                res_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
`ifndef DEC_ARB_FIXED_PRIO_EN
                    ptr_d       = id_q + 2'd1;
`endif
                end
            end
            default: begin
                gnt_d       = 4'b0000;
                res_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 2'd0;
            id_q        <= 2'd0;
            gnt_q       <= 4'b0000;
            res_q       <= '0;
            res_id_q    <= 2'd0;
            res_valid_q <= 1'b0;
`ifndef DEC_ARB_FIXED_PRIO_EN
            ptr_q       <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            id_q        <= id_d;
            gnt_q       <= gnt_d;
            res_q       <= res_d;
            res_id_q    <= res_id_d;
            res_valid_q <= res_valid_d;
`ifndef DEC_ARB_FIXED_PRIO_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign res       = res_q;
    assign res_id    = res_id_q;
    assign res_valid = res_valid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_decoder_gate_arbiter.sv
// Self-checking bench for decoder_gate_arbiter: directed vector table, reset/stall sequences,
// and random transactions scored against a behavioural arbitration/gate model.
module tb_decoder_gate_arbiter;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [3:0]     req;
    logic [4*W-1:0] op_a, op_b;
    logic [7:0]     op_sel;
    logic           res_ready;
    logic [3:0]     gnt;
    logic [W-1:0]   res;
    logic [1:0]     res_id;
    logic           res_valid;
    logic           busy;

    int total = 0;
    int bad   = 0;
    int mp    = 0;

    typedef struct {
        logic [3:0]     req;
        logic [4*W-1:0] a;
        logic [4*W-1:0] b;
        logic [7:0]     sel;
        int             stall;
        int             exp_id;
        logic [W-1:0]   exp_res;
    } vec_t;

    vec_t vt [13];

    decoder_gate_arbiter #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sel    (op_sel),
        .gnt       (gnt),
        .res       (res),
        .res_id    (res_id),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] op);
        case (op)
            2'd0:    return a ^ b;
            2'd1:    return ~(a ^ b);
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic int model_winner(input logic [3:0] r);
`ifdef DEC_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) if (r[i]) return i;
`else
        for (int k = 0; k < 4; k++) if (r[(mp + k) % 4]) return (mp + k) % 4;
`endif
        return 0;
    endfunction

    // One full transaction starting one step after a rising edge, while the DUT is idle.
    task automatic do_txn(input logic [3:0] r, input logic [4*W-1:0] a, input logic [4*W-1:0] b,
                          input logic [7:0] sel, input int stall, input int exp_id,
                          input logic [W-1:0] exp_res);
        req = r; op_a = a; op_b = b; op_sel = sel;
        res_ready = (stall == 0);
        @(posedge clk); #1;
        check("gnt", gnt, 32'(4'b0001 << exp_id));
        check("busy_exec", busy, 1);
        check("valid_exec", res_valid, 0);
        req = 4'($urandom); op_a = 16'($urandom); op_b = 16'($urandom); op_sel = 8'($urandom);
        @(posedge clk); #1;
        check("gnt_clear", gnt, 0);
        check("res", res, exp_res);
        check("res_id", res_id, exp_id);
        check("valid", res_valid, 1);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check("res_hold", res, exp_res);
            check("res_id_hold", res_id, exp_id);
            check("valid_hold", res_valid, 1);
            check("gnt_hold", gnt, 0);
            check("busy_hold", busy, 1);
            if (s == stall - 1) res_ready = 1'b1;
        end
        @(posedge clk); #1;
        req = 4'b0000;
        check("valid_done", res_valid, 0);
        check("busy_done", busy, 0);
        check("gnt_done", gnt, 0);
`ifndef DEC_ARB_FIXED_PRIO_EN
        mp = (exp_id + 1) % 4;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]     r;
        logic [4*W-1:0] a, b;
        logic [7:0]     sel;
        int             id;

        vt = '{
            '{4'b1111, 16'h9F3C, 16'h5A6E, 8'hAA, 0, 0, 4'hC},
            '{4'b1111, 16'h9F3C, 16'h5A6E, 8'hAA, 0, 1, 4'h2},
            '{4'b1111, 16'h9F3C, 16'h5A6E, 8'hAA, 0, 2, 4'hA},
            '{4'b1111, 16'h9F3C, 16'h5A6E, 8'hAA, 0, 3, 4'h1},
            '{4'b1111, 16'h9F3C, 16'h5A6E, 8'hAA, 0, 0, 4'hC},
            '{4'b0001, 16'h000C, 16'h000A, 8'h00, 0, 0, 4'h6},
            '{4'b0100, 16'h0300, 16'h0500, 8'h00, 0, 2, 4'h6},
            '{4'b0100, 16'h0300, 16'h0500, 8'h10, 0, 2, 4'h9},
            '{4'b0100, 16'h0300, 16'h0500, 8'h20, 0, 2, 4'h1},
            '{4'b0100, 16'h0300, 16'h0500, 8'h30, 0, 2, 4'h7},
            '{4'b0010, 16'h00A0, 16'h0060, 8'h04, 5, 1, 4'h3},
            '{4'b1001, 16'h5009, 16'h3003, 8'hC0, 1, 3, 4'h7},
            '{4'b1001, 16'h5009, 16'h3003, 8'hC0, 0, 0, 4'hA}
        };

        rst_n = 1'b0; req = '0; op_a = '0; op_b = '0; op_sel = '0; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_res", res, 0);
        check("rst_res_id", res_id, 0);
        check("rst_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;

        repeat (2) begin
            @(posedge clk); #1;
            check("idle_gnt", gnt, 0);
            check("idle_busy", busy, 0);
        end

`ifdef DEC_ARB_FIXED_PRIO_EN
        for (int n = 0; n < 4; n++)
            do_txn(4'b1010, 16'h9F3C, 16'h5A6E, 8'hFF, n % 2, 1, 4'h7);
`else
        for (int i = 0; i < 13; i++)
            do_txn(vt[i].req, vt[i].a, vt[i].b, vt[i].sel, vt[i].stall, vt[i].exp_id, vt[i].exp_res);
`endif

        // Reset pulse while the granted operation is executing.
        req = 4'b0010; op_a = 16'h00F0; op_b = 16'h00F0; op_sel = 8'h00; res_ready = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_gnt", gnt, 4'b0010);
        rst_n = 1'b0;
        #1;
        check("async_gnt", gnt, 0);
        check("async_valid", res_valid, 0);
        check("async_busy", busy, 0);
        check("async_res", res, 0);
        check("async_res_id", res_id, 0);
        #2 rst_n = 1'b1;
        req = 4'b0000;
        mp = 0;
        repeat (3) begin
            @(posedge clk); #1;
            check("post_rst_valid", res_valid, 0);
            check("post_rst_busy", busy, 0);
        end
        do_txn(4'b0100, 16'h0A00, 16'h0C00, 8'h20, 0, 2, 4'h8);
        do_txn(4'b1111, 16'h1234, 16'h4321, 8'h00, 0, model_winner(4'b1111),
               model_f(4'h1, 4'h4, 2'd0));

        for (int n = 0; n < 40; n++) begin
            r   = 4'($urandom_range(1, 15));
            a   = 16'($urandom);
            b   = 16'($urandom);
            sel = 8'($urandom);
            id  = model_winner(r);
            do_txn(r, a, b, sel, $urandom_range(0, 2), id,
                   model_f(a[id*W +: W], b[id*W +: W], sel[id*2 +: 2]));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                check("rand_idle_gnt", gnt, 0);
                check("rand_idle_busy", busy, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
